evt_buf_readout: RTL and testbench
==================================

// Module: evt_buf_readout
// PURPOSE
//  Drains the event buffer filled by the ring-to-event-buffer transfer FSM and frames each event for the DAQ link.
//  Tracks complete events (one EVT_DONE pulse per event, from the transfer FSM's NXT_L1A).
//  Per event it emits a header, SAMP_MAX*WORDS_PER_SAMP data words and two trailer words.
//  Sits between the event FIFO read port (first-word-fall-through) and the serializer input (valid/ready).
// PARAMETERS
//  WORDS_PER_SAMP  96  data words per sample in the event buffer
//  EVT_CNT_W        4  width of pending-event counter
// PORTS
//  CLK            in   1   system clock
//  RST            in   1   asynchronous reset, active-high
//  EVT_DONE       in   1   one-cycle pulse: one complete event written to buffer
//  L1A_NUM        in   12  L1A number of oldest pending event, valid while EVT_CNT>0
//  SAMP_MAX       in   7   samples per event (0..127)
//  EVT_BUF_EMPTY  in   1   event FIFO empty
//  EVT_BUF_DATA   in   16  event FIFO head word (FWFT)
//  EVT_BUF_RD     out  1   event FIFO read strobe (combinational)
//  DOUT           out  16  output word
//  DOUT_VLD       out  1   DOUT valid
//  DOUT_RDY       in   1   downstream accepts DOUT this cycle
//  EVT_CNT        out  4   pending complete events
//  OVFL           out  1   sticky: EVT_DONE while EVT_CNT saturated
//  BUSY           out  1   state != Idle
//  RO_STATE       out  3   current state encoding (debug)
// BEHAVIOUR
//  Reset: state=Idle, DOUT=0, DOUT_VLD=0, EVT_CNT=0, OVFL=0, word/chk regs=0; EVT_BUF_RD=0 (comb, Idle).
//  Output reg: load_ok = !DOUT_VLD | DOUT_RDY; accept = DOUT_VLD & DOUT_RDY.
//   DOUT/DOUT_VLD update only when load_ok; if load_ok and nothing new to load, DOUT_VLD<=0.
//  States (RO_STATE): Idle=0, Header=1, Data=2, Trl1=3, Trl2=4, Done=5.
//  Idle: EVT_CNT!=0 -> Header; latch nsamp=SAMP_MAX, total=SAMP_MAX*WORDS_PER_SAMP (14b), wcnt=0, chk=0.
//  Header: when load_ok, load DOUT={4'hA,L1A_NUM} (L1A_NUM sampled that cycle) -> Data (Trl1 if total==0).
//  Data: EVT_BUF_RD = !EVT_BUF_EMPTY & load_ok; on RD: DOUT<=EVT_BUF_DATA, VLD<=1, wcnt+=1,
//   chk^=EVT_BUF_DATA; RD with wcnt==total-1 -> Trl1. Empty FIFO: stall, no RD, no bubble error.
//  Trl1: when load_ok, DOUT={2'b11,wcnt[13:0]} -> Trl2.
//  Trl2: when load_ok, DOUT=chk (16b XOR of data words) -> Done.
//  Done: wait accept of Trl2 word (or !DOUT_VLD); then EVT_CNT decrement, -> Idle.
//  Idle->Header needs >=1 idle cycle between events (Done->Idle->Header).
//  EVT_BUF_RD never asserted outside Data; never exceeds total reads per event.
//  EVT_CNT: +1 on EVT_DONE, -1 on Done exit; both same cycle -> unchanged.
//   At 15 with EVT_DONE and no decrement: hold 15, set OVFL (cleared only by RST).
//  SAMP_MAX changes mid-event ignored (latched copy used).
//  DOUT_RDY low: DOUT and DOUT_VLD hold stable; no FIFO reads; state holds.
//  RST mid-event: immediate return to Idle, all outputs to reset values; FIFO not flushed here.
// TESTING
//  SAMP_MAX=1, FIFO preloaded 96 words 0x0000..0x005F, one EVT_DONE, L1A_NUM=0x123, RDY=1 ->
//   DOUT seq A123, 0000..005F, C060, chk=XOR(0..5F)=0x0000; EVT_CNT 1->0.
//  Same, DOUT_RDY toggled 1-of-3 cycles -> identical word sequence, DOUT stable while VLD&!RDY.
//  SAMP_MAX=0, one event -> DOUT A<L1A>, C000, 0000; EVT_BUF_RD never asserted.
//  FIFO empty for 10 cycles mid-Data -> no RD, no DOUT_VLD after drain; resumes, wcnt correct.
//  16 EVT_DONE pulses with RDY=0 -> EVT_CNT=15, OVFL=1; EVT_DONE coincident with Done exit -> unchanged.
//  RST asserted in Data (wcnt=40) -> next cycle Idle, DOUT_VLD=0, EVT_CNT=0, OVFL=0.

Source files
------------

// File: rtl/evt_buf_readout_if.sv
// Event-FIFO read port (FWFT) plus serializer valid/ready stream, bundled for the readout block.
// The master side is the readout engine; the slave side is the FIFO/serializer environment.
interface evt_buf_readout_if;
  logic        EVT_BUF_EMPTY;
  logic [15:0] EVT_BUF_DATA;
  logic        EVT_BUF_RD;
  logic [15:0] DOUT;
  logic        DOUT_VLD;
  logic        DOUT_RDY;

  modport master (
    input  EVT_BUF_EMPTY,
    input  EVT_BUF_DATA,
    input  DOUT_RDY,
    output EVT_BUF_RD,
    output DOUT,
    output DOUT_VLD
  );

  modport slave (
    output EVT_BUF_EMPTY,
    output EVT_BUF_DATA,
    output DOUT_RDY,
    input  EVT_BUF_RD,
    input  DOUT,
    input  DOUT_VLD
  );
endinterface

// File: rtl/evt_buf_readout.sv
// Event buffer readout: frames each complete event as header, data words and two trailers
// (word count, XOR checksum) onto a valid/ready stream, tracking pending events.
module evt_buf_readout #(
  parameter int WORDS_PER_SAMP = 96,
  parameter int EVT_CNT_W      = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EVT_DONE,
  input  logic [11:0]          L1A_NUM,
  input  logic [6:0]           SAMP_MAX,
  evt_buf_readout_if.master    bus,
  output logic [EVT_CNT_W-1:0] EVT_CNT,
  output logic                 OVFL,
  output logic                 BUSY,
  output logic [2:0]           RO_STATE
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_TRL1   = 3'd3,
    ST_TRL2   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [EVT_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [EVT_CNT_W-1:0] CNT_ONE = EVT_CNT_W'(1);

  state_t               state_q, state_d;
  logic [15:0]          dout_q, dout_d;
  logic                 dout_vld_q, dout_vld_d;
  logic [13:0]          total_q, total_d;
  logic [13:0]          wcnt_q, wcnt_d;
  logic [15:0]          chk_q, chk_d;
  logic [EVT_CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic                 ovfl_q, ovfl_d;

  logic        load_ok;
  logic        rd;
  logic        evt_dec;
  logic [13:0] samp_words;

  // Output register can take a new word when empty or when its current word leaves.
  assign load_ok    = !dout_vld_q || bus.DOUT_RDY;
  assign samp_words = 14'(SAMP_MAX) * 14'(WORDS_PER_SAMP);

  always_comb begin
    state_d    = state_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    total_d    = total_q;
    wcnt_d     = wcnt_q;
    chk_d      = chk_q;
    rd         = 1'b0;
    evt_dec    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_ok) begin
          dout_vld_d = 1'b0;
        end
        if (evt_cnt_q != '0) begin
          state_d = ST_HEADER;
          total_d = samp_words;
          wcnt_d  = '0;
          chk_d   = '0;
        end
      end

      ST_HEADER: begin
        if (load_ok) begin
          dout_d     = {4'hA, L1A_NUM};
          dout_vld_d = 1'b1;
          state_d    = (total_q == '0) ? ST_TRL1 : ST_DATA;
        end
      end

      ST_DATA: begin
        rd = !bus.EVT_BUF_EMPTY && load_ok;
        if (rd) begin
          dout_d     = bus.EVT_BUF_DATA;
          dout_vld_d = 1'b1;
          wcnt_d     = wcnt_q + 14'd1;
          chk_d      = chk_q ^ bus.EVT_BUF_DATA;
          if (wcnt_q == total_q - 14'd1) begin
            state_d = ST_TRL1;
          end
        end else if (load_ok) begin
          // FIFO starved: let the previous word drain and wait without a bubble marker.
          dout_vld_d = 1'b0;
        end
      end

      ST_TRL1: begin
        if (load_ok) begin
          dout_d     = {2'b11, wcnt_q};
          dout_vld_d = 1'b1;
          state_d    = ST_TRL2;
        end
      end

      ST_TRL2: begin
        if (load_ok) begin
          dout_d     = chk_q;
          dout_vld_d = 1'b1;
          state_d    = ST_DONE;
        end
      end

      ST_DONE: begin
        if (load_ok) begin
          dout_vld_d = 1'b0;
          evt_dec    = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        dout_vld_d = 1'b0;
      end
    endcase
  end

  // Pending-event counter saturates; an arrival lost to saturation is flagged sticky.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    ovfl_d    = ovfl_q;
    if (EVT_DONE && !evt_dec) begin
      if (evt_cnt_q == CNT_MAX) begin
        ovfl_d = 1'b1;
      end else begin
        evt_cnt_d = evt_cnt_q + CNT_ONE;
      end
    end else if (!EVT_DONE && evt_dec) begin
      evt_cnt_d = evt_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      total_q    <= '0;
      wcnt_q     <= '0;
      chk_q      <= '0;
      evt_cnt_q  <= '0;
      ovfl_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      total_q    <= total_d;
      wcnt_q     <= wcnt_d;
      chk_q      <= chk_d;
      evt_cnt_q  <= evt_cnt_d;
      ovfl_q     <= ovfl_d;
    end
  end

  assign bus.EVT_BUF_RD = rd;
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VLD   = dout_vld_q;
  assign EVT_CNT        = evt_cnt_q;
  assign OVFL           = ovfl_q;
  assign BUSY           = (state_q != ST_IDLE);
  assign RO_STATE       = state_q;

endmodule

// File: tb/tb_evt_buf_readout.sv
// Bench for evt_buf_readout: FWFT FIFO model, accepted-word monitor and expected-word scoreboard.
module tb_evt_buf_readout;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EVT_DONE = 1'b0;
  logic [11:0] L1A_NUM = '0;
  logic [6:0]  SAMP_MAX = '0;
  logic [3:0]  EVT_CNT;
  logic        OVFL;
  logic        BUSY;
  logic [2:0]  RO_STATE;

  evt_buf_readout_if bus();

  evt_buf_readout #(.WORDS_PER_SAMP(96), .EVT_CNT_W(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EVT_DONE (EVT_DONE),
    .L1A_NUM  (L1A_NUM),
    .SAMP_MAX (SAMP_MAX),
    .bus      (bus.master),
    .EVT_CNT  (EVT_CNT),
    .OVFL     (OVFL),
    .BUSY     (BUSY),
    .RO_STATE (RO_STATE)
  );

  always #5 CLK = ~CLK;

  // FWFT FIFO model
  logic [15:0] fifo_mem [0:4095];
  logic [11:0] wptr = '0;
  logic [11:0] rptr = '0;
  logic        hold_empty = 1'b0;
  assign bus.EVT_BUF_EMPTY = (rptr == wptr) || hold_empty;
  assign bus.EVT_BUF_DATA  = fifo_mem[rptr];
  always @(posedge CLK) if (bus.EVT_BUF_RD) rptr <= rptr + 12'd1;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  int          rd_cnt = 0;
  int          rd_outside = 0;
  int          stab_err = 0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_dout = '0;

  // Monitor samples on the falling edge, i.e. what the next rising edge will act on.
  always @(negedge CLK) begin
    if (RST) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (!bus.DOUT_VLD || bus.DOUT !== prev_dout)) stab_err++;
      if (bus.DOUT_VLD && bus.DOUT_RDY) obs_q.push_back(bus.DOUT);
      if (bus.EVT_BUF_RD) begin
        rd_cnt++;
        if (RO_STATE != 3'd2) rd_outside++;
      end
      prev_hold = bus.DOUT_VLD && !bus.DOUT_RDY;
      prev_dout = bus.DOUT;
    end
  end

  task automatic do_reset();
    EVT_DONE = 1'b0;
    hold_empty = 1'b0;
    bus.DOUT_RDY = 1'b1;
    RST = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    wptr = rptr;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic load_event(input logic [11:0] l1a, input int nwords, input bit rnd);
    logic [15:0] w;
    logic [15:0] chk;
    chk = '0;
    exp_q.push_back({4'hA, l1a});
    for (int i = 0; i < nwords; i++) begin
      w = rnd ? 16'($urandom) : 16'(i);
      fifo_mem[wptr] = w;
      wptr = wptr + 12'd1;
      exp_q.push_back(w);
      chk = chk ^ w;
    end
    exp_q.push_back({2'b11, 14'(nwords)});
    exp_q.push_back(chk);
  endtask

  task automatic pulse_evt();
    EVT_DONE = 1'b1;
    @(posedge CLK);
    #1;
    EVT_DONE = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input int budget, input bit throttle, output bit to);
    int cyc;
    cyc = 0;
    while (obs_q.size() < n && cyc < budget) begin
      @(posedge CLK);
      #1;
      if (throttle) bus.DOUT_RDY = ((cyc % 3) == 0);
      cyc++;
    end
    bus.DOUT_RDY = 1'b1;
    to = (obs_q.size() < n);
  endtask

  task automatic test_reset();
    #2;
    RST = 1'b1;
    #1;
    checks++; if (bus.DOUT_VLD !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", bus.DOUT_VLD); end
    checks++; if (bus.DOUT !== 16'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0000", bus.DOUT); end
    checks++; if (EVT_CNT !== 4'd0) begin errors++; $display("FAIL reset_evtcnt got=%0d exp=0", EVT_CNT); end
    checks++; if (OVFL !== 1'b0) begin errors++; $display("FAIL reset_ovfl got=%b exp=0", OVFL); end
    checks++; if (RO_STATE !== 3'd0 || BUSY !== 1'b0) begin errors++; $display("FAIL reset_state got=%0d busy=%b exp=0/0", RO_STATE, BUSY); end
    checks++; if (bus.EVT_BUF_RD !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", bus.EVT_BUF_RD); end
    do_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (RO_STATE !== 3'd0 || bus.DOUT_VLD !== 1'b0) begin errors++; $display("FAIL idle_hold state=%0d vld=%b exp=0/0", RO_STATE, bus.DOUT_VLD); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit to;
    int rd0;
    logic [15:0] e, o;
    do_reset();
    SAMP_MAX = 7'd1;
    L1A_NUM = 12'h123;
    rd0 = rd_cnt;
    load_event(12'h123, 96, 1'b0);
    pulse_evt();
    checks++; if (EVT_CNT !== 4'd1) begin errors++; $display("FAIL basic_cnt_up got=%0d exp=1", EVT_CNT); end
    wait_outputs(99, 400, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got=%0d words exp=99", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL basic_word got=%h exp=%h", o, e); end
    end
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (EVT_CNT !== 4'd0) begin errors++; $display("FAIL basic_cnt_down got=%0d exp=0", EVT_CNT); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy got=%b exp=0", BUSY); end
    checks++; if (rd_cnt - rd0 != 96) begin errors++; $display("FAIL basic_reads got=%0d exp=96", rd_cnt - rd0); end
    checks++; if (rd_outside != 0) begin errors++; $display("FAIL basic_rd_outside got=%0d exp=0", rd_outside); end
    $display("test_basic done: event L1A=123 framed");
  endtask

  task automatic test_throttle();
    bit to;
    logic [15:0] e, o;
    do_reset();
    SAMP_MAX = 7'd1;
    L1A_NUM = 12'h4B7;
    load_event(12'h4B7, 96, 1'b1);
    pulse_evt();
    @(posedge CLK);
    #1;
    SAMP_MAX = 7'd3;
    wait_outputs(99, 800, 1'b1, to);
    checks++; if (to) begin errors++; $display("FAIL throttle_timeout got=%0d words exp=99", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL throttle_word got=%h exp=%h", o, e); end
    end
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL throttle_extra got=%0d words exp=0", obs_q.size()); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL throttle_stable got=%0d exp=0", stab_err); end
    checks++; if (EVT_CNT !== 4'd0) begin errors++; $display("FAIL throttle_cnt got=%0d exp=0", EVT_CNT); end
    $display("test_throttle done: 1-of-3 ready");
  endtask

  task automatic test_samp0();
    bit to;
    int rd0;
    logic [15:0] e, o;
    do_reset();
    SAMP_MAX = 7'd0;
    L1A_NUM = 12'h3C5;
    rd0 = rd_cnt;
    load_event(12'h3C5, 0, 1'b0);
    pulse_evt();
    wait_outputs(3, 50, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL samp0_timeout got=%0d words exp=3", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL samp0_word got=%h exp=%h", o, e); end
    end
    checks++; if (rd_cnt != rd0) begin errors++; $display("FAIL samp0_reads got=%0d exp=0", rd_cnt - rd0); end
    $display("test_samp0 done");
  endtask

  task automatic test_empty_stall();
    bit to;
    bit found;
    int rd0;
    logic [15:0] e, o;
    do_reset();
    SAMP_MAX = 7'd1;
    L1A_NUM = 12'h7E1;
    rd0 = rd_cnt;
    load_event(12'h7E1, 96, 1'b1);
    pulse_evt();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge CLK);
      #1;
      if (rd_cnt - rd0 == 40) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL stall_reach got=%0d reads exp=40", rd_cnt - rd0); end
    hold_empty = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    checks++; if (rd_cnt - rd0 != 40) begin errors++; $display("FAIL stall_no_rd got=%0d exp=40", rd_cnt - rd0); end
    checks++; if (bus.DOUT_VLD !== 1'b0) begin errors++; $display("FAIL stall_drained got=%b exp=0", bus.DOUT_VLD); end
    checks++; if (RO_STATE !== 3'd2) begin errors++; $display("FAIL stall_state got=%0d exp=2", RO_STATE); end
    hold_empty = 1'b0;
    wait_outputs(99, 400, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got=%0d words exp=99", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stall_word got=%h exp=%h", o, e); end
    end
    checks++; if (rd_cnt - rd0 != 96) begin errors++; $display("FAIL stall_reads got=%0d exp=96", rd_cnt - rd0); end
    $display("test_empty_stall done");
  endtask

  task automatic test_ovfl();
    bit found;
    do_reset();
    SAMP_MAX = 7'd0;
    L1A_NUM = 12'h055;
    bus.DOUT_RDY = 1'b0;
    repeat (15) pulse_evt();
    checks++; if (EVT_CNT !== 4'd15 || OVFL !== 1'b0) begin errors++; $display("FAIL ovfl_15 got=%0d/%b exp=15/0", EVT_CNT, OVFL); end
    pulse_evt();
    checks++; if (EVT_CNT !== 4'd15 || OVFL !== 1'b1) begin errors++; $display("FAIL ovfl_16 got=%0d/%b exp=15/1", EVT_CNT, OVFL); end
    bus.DOUT_RDY = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge CLK);
      #1;
      if (RO_STATE == 3'd5) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL ovfl_done1 got=%0d exp=5", RO_STATE); end
    pulse_evt();
    checks++; if (EVT_CNT !== 4'd15 || OVFL !== 1'b1) begin errors++; $display("FAIL ovfl_coincident got=%0d/%b exp=15/1", EVT_CNT, OVFL); end
    checks++; if (RO_STATE !== 3'd0) begin errors++; $display("FAIL ovfl_exit got=%0d exp=0", RO_STATE); end
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(posedge CLK);
      #1;
      if (RO_STATE == 3'd5) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL ovfl_done2 got=%0d exp=5", RO_STATE); end
    @(posedge CLK);
    #1;
    checks++; if (EVT_CNT !== 4'd14) begin errors++; $display("FAIL ovfl_dec got=%0d exp=14", EVT_CNT); end
    $display("test_ovfl done");
  endtask

  task automatic test_rst_mid();
    bit found;
    int rd0;
    do_reset();
    SAMP_MAX = 7'd1;
    L1A_NUM = 12'h2AA;
    rd0 = rd_cnt;
    load_event(12'h2AA, 96, 1'b1);
    pulse_evt();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(posedge CLK);
      #1;
      if (rd_cnt - rd0 == 40) found = 1'b1;
    end
    checks++; if (!found || RO_STATE !== 3'd2) begin errors++; $display("FAIL rstmid_reach got=%0d reads state=%0d exp=40/2", rd_cnt - rd0, RO_STATE); end
    RST = 1'b1;
    #1;
    checks++; if (RO_STATE !== 3'd0) begin errors++; $display("FAIL rstmid_state got=%0d exp=0", RO_STATE); end
    checks++; if (bus.DOUT_VLD !== 1'b0 || bus.DOUT !== 16'h0) begin errors++; $display("FAIL rstmid_dout got=%b/%h exp=0/0000", bus.DOUT_VLD, bus.DOUT); end
    checks++; if (EVT_CNT !== 4'd0 || OVFL !== 1'b0) begin errors++; $display("FAIL rstmid_cnt got=%0d/%b exp=0/0", EVT_CNT, OVFL); end
    checks++; if (bus.EVT_BUF_RD !== 1'b0) begin errors++; $display("FAIL rstmid_rd got=%b exp=0", bus.EVT_BUF_RD); end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    $display("test_rst_mid done");
  endtask

  initial begin
    bus.DOUT_RDY = 1'b1;
    test_reset();
    test_basic();
    test_throttle();
    test_samp0();
    test_empty_stall();
    test_ovfl();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
